phy_reg_free_list_ctrl: RTL and testbench

- Controller that owns the pool of free physical registers for the rename stage.
- Fills itself after reset, then hands one free physical register per cycle to the rename logic through an alloc request/grant handshake.
- Takes back one released physical register per cycle from commit.
- Sits between the commit interface (commit_valid / commit_with_write / commited_wr_register) and the architectural register map. `empty` drives the rename stall (`can_rename`).

---
 rtl/phy_reg_free_list_ctrl.sv | 143 ++++++++++++++
 tb/tb_phy_reg_free_list_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/phy_reg_free_list_ctrl.sv
// Free physical register pool for rename: self-fills after reset, then allocates from
// the head and accepts releases at the tail. Optional duplicate-release detection: PHY_FREE_LIST_DUP_CHECK_EN.
module phy_reg_free_list_ctrl #(
  parameter int PHYSICAL_REG_NUM_WIDTH = 7,
  parameter int ARCH_REG_NUM           = 32
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              alloc_req_i,
  output logic                              alloc_gnt_o,
  output logic [PHYSICAL_REG_NUM_WIDTH-1:0] alloc_reg_o,
  input  logic                              free_valid_i,
  input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] free_reg_i,
  output logic [PHYSICAL_REG_NUM_WIDTH:0]   free_count_o,
  output logic                              empty_o,
  output logic                              init_done_o,
  output logic                              error_o
);

  localparam int PHYS_NUM = 2 ** PHYSICAL_REG_NUM_WIDTH;
  localparam int DEPTH    = PHYS_NUM - ARCH_REG_NUM;
  localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W    = PHYSICAL_REG_NUM_WIDTH + 1;
  localparam int RW       = PHYSICAL_REG_NUM_WIDTH;

  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [RW-1:0]    REG_FIRST = RW'(ARCH_REG_NUM);
  localparam logic [RW-1:0]    REG_LAST  = RW'(PHYS_NUM - 1);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t            state_q, state_d;
  logic              in_init, ready;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RW-1:0]     init_val_q, init_val_d;
  logic              error_q, error_d;
  logic [RW-1:0]     mem_q [DEPTH];
  logic [RW-1:0]     head, wr_data;
  logic              gnt, wr_en, accept, bad_x0, bad_ovf, dup;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (!reset_i) state_q <= ST_INIT;
    else          state_q <= state_d;
  end

  // FSM: next state; INIT ends on the cycle that writes the last physical register
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  if (init_val_q == REG_LAST) state_d = ST_READY;
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_INIT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_init = 1'b0;
    ready   = 1'b0;
    case (state_q)
      ST_INIT:  in_init = 1'b1;
      ST_READY: ready   = 1'b1;
      default:  ;
    endcase
  end

  assign head    = mem_q[rd_ptr_q];
  assign gnt     = ready & alloc_req_i & (cnt_q != '0);
  assign bad_x0  = (free_reg_i == '0);
  assign bad_ovf = (cnt_q == CNT_FULL) & ~gnt;
  assign accept  = ready & free_valid_i & ~bad_x0 & ~bad_ovf & ~dup;
  assign wr_en   = in_init | accept;
  assign wr_data = in_init ? init_val_q : free_reg_i;

`ifdef PHY_FREE_LIST_DUP_CHECK_EN
  logic [PHYS_NUM-1:0] in_list_q, in_list_d;

  // A release of the register being granted this cycle is legitimate.
  assign dup = in_list_q[free_reg_i] & ~(gnt & (head == free_reg_i));

  always_comb begin
    in_list_d = in_list_q;
    if (gnt)   in_list_d[head]    = 1'b0;
    if (wr_en) in_list_d[wr_data] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) in_list_q <= '0;
    else          in_list_q <= in_list_d;
  end
`else
  assign dup = 1'b0;
`endif

  always_comb begin
    rd_ptr_d   = gnt   ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d   = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    init_val_d = in_init ? init_val_q + 1'b1 : init_val_q;
    error_d    = error_q | (ready & free_valid_i & (bad_x0 | bad_ovf | dup));
    cnt_d      = cnt_q;
    case ({wr_en, gnt})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      init_val_q <= REG_FIRST;
      error_q    <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      init_val_q <= init_val_d;
      error_q    <= error_d;
    end
  end

  // Storage is not reset; every entry is written during INIT before it can be read.
  always_ff @(posedge clk_i) begin
    if (reset_i && wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign alloc_gnt_o  = gnt;
  assign alloc_reg_o  = (ready && cnt_q != '0) ? head : '0;
  assign free_count_o = cnt_q;
  assign empty_o      = (cnt_q == '0) | ~ready;
  assign init_done_o  = ready;
  assign error_o      = error_q;

endmodule

// File: tb/tb_phy_reg_free_list_ctrl.sv
// Scoreboard bench for phy_reg_free_list_ctrl; follows PHY_FREE_LIST_DUP_CHECK_EN like the design.
module tb_phy_reg_free_list_ctrl;

  localparam int W        = 7;
  localparam int ARCH     = 32;
  localparam int PHYS_NUM = 2 ** W;
  localparam int DEPTH    = PHYS_NUM - ARCH;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         alloc_req = 1'b0;
  logic         alloc_gnt;
  logic [W-1:0] alloc_reg;
  logic         free_valid = 1'b0;
  logic [W-1:0] free_reg = '0;
  logic [W:0]   free_count;
  logic         empty;
  logic         init_done;
  logic         error;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: the expected free list acts as the scoreboard queue
  int m_list[$];
  bit m_ready    = 1'b0;
  int m_init_val = ARCH;
  bit m_err      = 1'b0;
  bit m_inlist [PHYS_NUM];

  phy_reg_free_list_ctrl #(
    .PHYSICAL_REG_NUM_WIDTH(W),
    .ARCH_REG_NUM(ARCH)
  ) dut (
    .clk_i(clk),
    .reset_i(reset),
    .alloc_req_i(alloc_req),
    .alloc_gnt_o(alloc_gnt),
    .alloc_reg_o(alloc_reg),
    .free_valid_i(free_valid),
    .free_reg_i(free_reg),
    .free_count_o(free_count),
    .empty_o(empty),
    .init_done_o(init_done),
    .error_o(error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive, check outputs against the model at negedge, advance the model at posedge.
  task automatic step(input bit rst, input bit req, input bit fv, input int freg);
    bit e_gnt, x0, ovf, dup, acc;
    int popped;
    reset      = rst;
    alloc_req  = req;
    free_valid = fv;
    free_reg   = W'(freg);
    @(negedge clk);
    e_gnt = m_ready && req && (m_list.size() > 0);
    check_eq("alloc_gnt", alloc_gnt, e_gnt);
    check_eq("alloc_reg", alloc_reg, (m_ready && m_list.size() > 0) ? m_list[0] : 0);
    check_eq("free_count", free_count, m_list.size());
    check_eq("empty", empty, (m_list.size() == 0) || !m_ready);
    check_eq("init_done", init_done, m_ready);
    check_eq("error", error, m_err);
    if (!rst) begin
      m_list.delete();
      m_ready    = 1'b0;
      m_init_val = ARCH;
      m_err      = 1'b0;
      foreach (m_inlist[i]) m_inlist[i] = 1'b0;
    end else if (!m_ready) begin
      m_list.push_back(m_init_val);
      m_inlist[m_init_val] = 1'b1;
      if (m_init_val == PHYS_NUM - 1) m_ready = 1'b1;
      m_init_val++;
    end else begin
      popped = -1;
      ovf = (m_list.size() == DEPTH) && !e_gnt;
      if (e_gnt) begin
        popped = m_list.pop_front();
        m_inlist[popped] = 1'b0;
      end
      if (fv) begin
        x0 = (freg == 0);
`ifdef PHY_FREE_LIST_DUP_CHECK_EN
        dup = m_inlist[freg] && (popped != freg);
`else
        dup = 1'b0;
`endif
        acc = !x0 && !ovf && !dup;
        if (acc) begin
          m_list.push_back(freg);
          m_inlist[freg] = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (!init_done && n < 200) begin
      step(1, 0, 0, 0);
      n++;
    end
    check_eq(tag, n, DEPTH);
  endtask

  initial begin
    // reset and fill
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    wait_init("init_cycles");
    check_eq("init_count", free_count, 96);
    check_eq("init_head", alloc_reg, 32);
    check_eq("init_empty", empty, 0);

    // drain with one extra request
    for (int i = 0; i < 97; i++) step(1, 1, 0, 0);
    check_eq("drain_count", free_count, 0);
    check_eq("drain_empty", empty, 1);

    // free into empty list: no bypass
    step(1, 1, 1, 5);
    check_eq("nobypass_count", free_count, 1);
    step(1, 1, 0, 0);
    check_eq("nobypass_after", free_count, 0);

    // refill completely, then overflow
    for (int r = ARCH; r < PHYS_NUM; r++) step(1, 0, 1, r);
    check_eq("refill_count", free_count, 96);
    step(1, 0, 1, 40);
    check_eq("ovf_error", error, 1);
    check_eq("ovf_count", free_count, 96);

    // full list: grant + release of the granted register, wrapping both pointers
    for (int i = 0; i < 200; i++) step(1, 1, 1, m_list[0]);
    check_eq("pairs_count", free_count, 96);

    // reset in the middle of INIT
    step(0, 0, 0, 0);
    for (int i = 0; i < 50; i++) step(1, 0, 0, 0);
    step(0, 1, 1, 9);
    check_eq("midreset_done", init_done, 0);
    check_eq("midreset_count", free_count, 0);
    check_eq("midreset_err", error, 0);
    wait_init("reinit_cycles");

    // x0 release
    step(1, 1, 0, 0);
    step(1, 0, 1, 0);
    check_eq("x0_error", error, 1);
    check_eq("x0_count", free_count, 95);

    // duplicate release behaviour
    step(0, 0, 0, 0);
    wait_init("dup_init");
    step(1, 1, 0, 0);
    step(1, 0, 1, 33);
`ifdef PHY_FREE_LIST_DUP_CHECK_EN
    check_eq("dup33_error", error, 1);
    check_eq("dup33_count", free_count, 95);
    step(1, 0, 1, 32);
    check_eq("dup32_count", free_count, 96);
`else
    check_eq("dup33_error", error, 0);
    check_eq("dup33_count", free_count, 96);
`endif

    // random traffic from a fresh list
    step(0, 0, 0, 0);
    wait_init("rand_init");
    for (int i = 0; i < 400; i++)
      step(1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, PHYS_NUM - 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
